// File: rtl/cpu_pkg.sv
// Shared CPU datapath package: word width and skid-buffer state encoding.
// Used by result_skid_reg16 and result_slot.
package cpu_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    function automatic logic word_is_zero(input logic [WORD_W-1:0] w);
        return (w == '0);
    endfunction

endpackage

// File: rtl/result_slot.sv
// One result storage entry: data plus optional zr/ng flags.
// Flag storage exists only when CPU_RESULT_FLAGS_EN is defined.
module result_slot
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
`ifdef CPU_RESULT_FLAGS_EN
    input  logic             zr_i,
    input  logic             ng_i,
    output logic             zr_o,
    output logic             ng_o,
`endif
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

`ifdef CPU_RESULT_FLAGS_EN
    logic zr_q;
    logic ng_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            zr_q <= 1'b0;
            ng_q <= 1'b0;
        end else if (ld_i) begin
            zr_q <= zr_i;
            ng_q <= ng_i;
        end
    end

    assign zr_o = zr_q;
    assign ng_o = ng_q;
`endif

endmodule

// File: rtl/result_skid_reg16.sv
// Registered 2-entry skid output stage for 16-bit logic-unit results.
// Optional per-entry zr/ng flags via CPU_RESULT_FLAGS_EN.
module result_skid_reg16
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zr,
    output logic             out_ng,
    input  logic             out_ready
);

    skid_state_t state_q;
    skid_state_t state_d;
    logic        in_ready_q;

    logic accept;
    logic pop;
    logic main_ld;
    logic main_from_skid;
    logic skid_ld;

    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] main_d;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_ld = 1'b1;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    main_ld = 1'b1;
                end else if (accept) begin
                    skid_ld = 1'b1;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can move us
                if (pop) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign main_d = main_from_skid ? skid_q : in_data;

`ifdef CPU_RESULT_FLAGS_EN
    logic in_zr;
    logic in_ng;
    logic main_zr_d;
    logic main_ng_d;
    logic main_zr_q;
    logic main_ng_q;
    logic skid_zr_q;
    logic skid_ng_q;

    assign in_zr     = (in_data == '0);
    assign in_ng     = in_data[WIDTH-1];
    assign main_zr_d = main_from_skid ? skid_zr_q : in_zr;
    assign main_ng_d = main_from_skid ? skid_ng_q : in_ng;

    result_slot #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .clr_i (reset),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .zr_i  (main_zr_d),
        .ng_i  (main_ng_d),
        .zr_o  (main_zr_q),
        .ng_o  (main_ng_q),
        .q_o   (main_q)
    );

    result_slot #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .clr_i (reset),
        .ld_i  (skid_ld),
        .d_i   (in_data),
        .zr_i  (in_zr),
        .ng_i  (in_ng),
        .zr_o  (skid_zr_q),
        .ng_o  (skid_ng_q),
        .q_o   (skid_q)
    );

    assign out_zr = main_zr_q;
    assign out_ng = main_ng_q;
`else
    result_slot #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .clr_i (reset),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    result_slot #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .clr_i (reset),
        .ld_i  (skid_ld),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

    assign out_zr = 1'b0;
    assign out_ng = 1'b0;
`endif

    assign out_data = main_q;

endmodule

// File: tb/tb_result_skid_reg16.sv
// Directed bench for result_skid_reg16 (flag expectations follow
// CPU_RESULT_FLAGS_EN).
module tb_result_skid_reg16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_zr;
    logic        out_ng;
    logic        out_ready;

    int n_vec = 0;
    int n_bad = 0;

`ifdef CPU_RESULT_FLAGS_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    result_skid_reg16 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_zr    (out_zr),
        .out_ng    (out_ng),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;

        tick();
        in_valid = 1'b1;
        in_data  = 16'h7777;
        tick();
        chk("rst_in_ready", 16'(in_ready), 16'd0);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_zr", 16'(out_zr), 16'd0);
        chk("rst_ng", 16'(out_ng), 16'd0);

        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        chk("rel_in_ready", 16'(in_ready), 16'd1);
        chk("rel_out_valid", 16'(out_valid), 16'd0);

        in_valid = 1'b1;
        in_data  = 16'h00FF;
        tick();
        in_valid = 1'b0;
        chk("one_valid", 16'(out_valid), 16'd1);
        chk("one_data", out_data, 16'h00FF);
        chk("one_zr", 16'(out_zr), 16'd0);
        chk("one_ng", 16'(out_ng), 16'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("one_popped", 16'(out_valid), 16'd0);

        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        chk("bp_rdy1", 16'(in_ready), 16'd1);
        in_data = 16'h8000;
        tick();
        chk("bp_full_rdy", 16'(in_ready), 16'd0);
        chk("bp_head", out_data, 16'h1234);
        in_data = 16'hFFFF;
        tick();
        chk("bp_ign_rdy", 16'(in_ready), 16'd0);
        chk("bp_ign_head", out_data, 16'h1234);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_valid", 16'(out_valid), 16'd1);
        chk("bp_pop1_data", out_data, 16'h8000);
        chk("bp_pop1_ng", 16'(out_ng), 16'(FL));
        chk("bp_pop1_zr", 16'(out_zr), 16'd0);
        chk("bp_pop1_rdy", 16'(in_ready), 16'd1);
        tick();
        out_ready = 1'b0;
        chk("bp_empty", 16'(out_valid), 16'd0);
        chk("bp_hold", out_data, 16'h8000);

        in_valid = 1'b1;
        in_data  = 16'h0000;
        tick();
        in_valid = 1'b0;
        chk("zero_valid", 16'(out_valid), 16'd1);
        chk("zero_data", out_data, 16'h0000);
        chk("zero_zr", 16'(out_zr), 16'(FL));
        chk("zero_ng", 16'(out_ng), 16'd0);
        out_ready = 1'b1;
        tick();
        chk("zero_popped", 16'(out_valid), 16'd0);

        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 16'(i);
            tick();
            chk("st_valid", 16'(out_valid), 16'd1);
            chk("st_data", out_data, 16'(i));
            chk("st_rdy", 16'(in_ready), 16'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("st_drain", 16'(out_valid), 16'd0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hAAAA;
        tick();
        in_data = 16'h5555;
        tick();
        chk("mr_full", 16'(in_ready), 16'd0);
        chk("mr_head", out_data, 16'hAAAA);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        chk("mr_valid", 16'(out_valid), 16'd0);
        chk("mr_rdy", 16'(in_ready), 16'd0);
        chk("mr_data", out_data, 16'h0000);
        reset = 1'b0;
        tick();
        chk("mr_post_valid", 16'(out_valid), 16'd0);
        chk("mr_post_rdy", 16'(in_ready), 16'd1);
        tick();
        chk("mr_post_valid2", 16'(out_valid), 16'd0);
        chk("mr_post_data", out_data, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
